// File: rtl/multiplicador_secuencial.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock.
// Latency: TAMANO+1 edges from the edge sampling start to done; start accepted only in IDLE.
// Ports: clk, rst (async, active-high), start/A/B in; Result (2*TAMANO), busy, done out.
module multiplicador_secuencial #(
   parameter int TAMANO = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [TAMANO-1:0]     A,
   input  logic [TAMANO-1:0]     B,
   output logic [2*TAMANO-1:0]   Result,
   output logic                  busy,
   output logic                  done
);

   localparam int PW = 2 * TAMANO;
   localparam int CW = $clog2(TAMANO + 1);
   localparam int IW = (TAMANO > 1) ? $clog2(TAMANO) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [TAMANO-1:0] a_reg, a_nxt;
   logic [TAMANO-1:0] b_reg, b_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [PW-1:0]     acc, acc_nxt;
   logic [PW-1:0]     result_nxt;
   logic              done_nxt;

   logic              b_bit;
   logic [PW-1:0]     pp;
   logic [PW-1:0]     sum;

   // cnt never exceeds TAMANO-1 while in RUN, so its low IW bits suffice as a bit index.
   assign b_bit = b_reg[cnt[IW-1:0]];
   // Multiplicand is zero-extended before the shift so no partial-product bit is lost.
   assign pp    = b_bit ? ({{TAMANO{1'b0}}, a_reg} << cnt) : '0;
   assign sum   = acc + pp;

   always_comb begin
      state_nxt  = state;
      a_nxt      = a_reg;
      b_nxt      = b_reg;
      cnt_nxt    = cnt;
      acc_nxt    = acc;
      result_nxt = Result;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               a_nxt     = A;
               b_nxt     = B;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            acc_nxt = sum;
            cnt_nxt = cnt + CW'(1);
            // Last bit: publish the sum including this final partial product.
            if (cnt == CW'(TAMANO - 1)) begin
               result_nxt = sum;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         cnt    <= '0;
         acc    <= '0;
         Result <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         a_reg  <= a_nxt;
         b_reg  <= b_nxt;
         cnt    <= cnt_nxt;
         acc    <= acc_nxt;
         Result <= result_nxt;
         done   <= done_nxt;
      end
   end

   assign busy = (state == RUN);

endmodule
